// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - multi-channel arbiter onto one synchronous SRAM port with an RD_LAT-deep response tag pipeline
// Optional round-robin arbitration via macro SRAM_ARB_RR_EN; fixed highest-index priority otherwise.
module sram_arbiter #(
  parameter int NCH    = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RAM_AW = 14,
  parameter int RD_LAT = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NCH-1:0]             req,
  input  logic [NCH-1:0]             wr,
  input  logic [NCH*DATA_W/8-1:0]    wstrb,
  input  logic [NCH*ADDR_W-1:0]      addr,
  input  logic [NCH*DATA_W-1:0]      wdata,
  output logic [NCH-1:0]             addr_ok,
  output logic [NCH-1:0]             data_ok,
  output logic [DATA_W-1:0]          rdata,
  output logic                       ram_en,
  output logic [DATA_W/8-1:0]        ram_wen,
  output logic [RAM_AW-1:0]          ram_addr,
  output logic [DATA_W-1:0]          ram_wdata,
  input  logic [DATA_W-1:0]          ram_rdata
);
  localparam int NB   = DATA_W / 8;
  localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;

  logic            gnt_vld;
  logic [CH_W-1:0] gnt_id;
  logic [RD_LAT-1:0] vld_q, vld_d;
  logic [CH_W-1:0]   id_q [RD_LAT];
  logic [CH_W-1:0]   id_d [RD_LAT];
  logic              unused_addr_bits;

  assign unused_addr_bits = ^addr;

`ifdef SRAM_ARB_RR_EN
  logic [CH_W-1:0] ptr_q, ptr_d;

  // Descending k so the channel right after the pointer is assigned last and wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = '0;
    for (int k = NCH; k >= 1; k--) begin
      if (req[(int'(ptr_q) + k) % NCH]) begin
        gnt_vld = 1'b1;
        gnt_id  = CH_W'((int'(ptr_q) + k) % NCH);
      end
    end
    if (rst) gnt_vld = 1'b0;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_vld) ptr_d = gnt_id;
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= CH_W'(NCH - 1);
    else     ptr_q <= ptr_d;
  end
`else
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = '0;
    for (int i = 0; i < NCH; i++) begin
      if (req[i]) begin
        gnt_vld = 1'b1;
        gnt_id  = CH_W'(i);
      end
    end
    if (rst) gnt_vld = 1'b0;
  end
`endif

  always_comb begin
    addr_ok   = gnt_vld ? (NCH'(1) << gnt_id) : '0;
    ram_en    = gnt_vld;
    ram_addr  = addr[int'(gnt_id)*ADDR_W+2 +: RAM_AW];
    ram_wdata = wdata[int'(gnt_id)*DATA_W +: DATA_W];
    ram_wen   = (gnt_vld && wr[gnt_id]) ? wstrb[int'(gnt_id)*NB +: NB] : '0;
  end

  always_comb begin
    vld_d    = '0;
    vld_d[0] = gnt_vld;
    id_d[0]  = gnt_id;
    for (int i = 1; i < RD_LAT; i++) begin
      vld_d[i] = vld_q[i-1];
      id_d[i]  = id_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) vld_q <= '0;
    else     vld_q <= vld_d;
    for (int i = 0; i < RD_LAT; i++) id_q[i] <= id_d[i];
  end

  // Responses are masked during reset because the valids only clear at the edge.
  always_comb begin
    data_ok = (vld_q[RD_LAT-1] && !rst) ? (NCH'(1) << id_q[RD_LAT-1]) : '0;
    rdata   = ram_rdata;
  end
endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter NCH, default 2, number of requester channels (1..8); channel 0 = instruction, channel NCH-1 = data.
REQ-002 SHALL have parameter ADDR_W, default 32, requester byte-address width.
REQ-003 SHALL have parameter DATA_W, default 32, data width (multiple of 8).
REQ-004 SHALL have parameter RAM_AW, default 14, backend word-address width.
REQ-005 SHALL have parameter RD_LAT, default 1, backend read latency in cycles (1..4).
REQ-006 SHALL have port clk input 1: single clock; all logic on its rising edge.
REQ-007 SHALL have port rst input 1: reset, synchronous, active-high.
REQ-008 SHALL have ports req input NCH, wr input NCH, wstrb input NCH*DATA_W/8, addr input NCH*ADDR_W, wdata input NCH*DATA_W: per-channel requests, channel i in slice i.
REQ-009 SHALL have ports addr_ok output NCH (request accepted), data_ok output NCH (response valid), rdata output DATA_W (shared read data).
REQ-010 SHALL have ports ram_en output 1, ram_wen output DATA_W/8, ram_addr output RAM_AW, ram_wdata output DATA_W, ram_rdata input DATA_W: backend synchronous RAM port.

Function
REQ-011 SHALL grant at most one channel per cycle; grant is combinational from req that cycle; addr_ok is one-hot or zero.
REQ-012 SHALL, on grant of channel g, drive ram_en=1, ram_addr=addr_g[RAM_AW+1:2], ram_wdata=wdata_g, ram_wen=wstrb_g if wr_g else 0, all in the grant cycle.
REQ-013 SHALL drive ram_en=0, ram_wen=0 in cycles with no grant; a request with wr=1 and wstrb=0 is accepted and produces no byte write.
REQ-014 SHALL carry {valid, channel id} through an RD_LAT-deep tag pipeline; data_ok[g] asserts exactly RD_LAT cycles after the grant, for one cycle, for reads and writes alike.
REQ-015 SHALL drive rdata = ram_rdata in any cycle where a read response is signalled; rdata is don't-care otherwise and for write responses.
REQ-016 SHALL accept a new request every cycle (fully pipelined, up to RD_LAT in flight); responses return in grant order.
REQ-017 SHALL, in default mode, use fixed priority: highest-index requesting channel wins.
REQ-018 SHALL permit simultaneous grant to channel g and data_ok to the same or another channel in one cycle.
REQ-019 SHALL hold no request state: a requester not granted keeps req asserted; dropping req before addr_ok cancels it with no side effect.
REQ-020 SHALL ignore addr bits [1:0] and bits above RAM_AW+1 (wrap-around aliasing).

Reset
REQ-021 SHALL, while rst=1, clear all tag-pipeline valids and force addr_ok=0, data_ok=0, ram_en=0, ram_wen=0.
REQ-022 SHALL discard in-flight transactions on reset mid-operation: no data_ok for them after rst deasserts; first grant possible in the cycle after rst falls.
REQ-023 SHALL reset the round-robin pointer (when compiled) to channel NCH-1 so channel 0 has first priority.

Configuration
REQ-024 SHALL, with macro SRAM_ARB_RR_EN defined, use round-robin: search starts at pointer+1 modulo NCH; pointer updates to the granted channel on each grant, unchanged otherwise.
REQ-025 SHALL, without SRAM_ARB_RR_EN, implement fixed priority per REQ-017 with no pointer register.

Verification
REQ-026 SHALL cover: NCH=2, RD_LAT=1, ch0 read addr 0x0000_0010 while ram word 4=0xDEADBEEF -> addr_ok[0] cycle N, ram_addr=4, data_ok[0] cycle N+1, rdata=0xDEADBEEF.
REQ-027 SHALL cover: ch1 write addr 0x20 wstrb 0b0011 wdata 0x12345678, then read addr 0x20 after prior word 0 -> ram_wen=0b0011 on write; read returns 0x00005678.
REQ-028 SHALL cover: both channels req continuously for 4 cycles, fixed priority -> addr_ok[1] all 4 cycles, ch0 starved; with SRAM_ARB_RR_EN -> grants alternate 0,1,0,1.
REQ-029 SHALL cover: RD_LAT=3, back-to-back reads ch1 then ch0 in cycles N, N+1 -> data_ok[1] at N+3, data_ok[0] at N+4, in order.
REQ-030 SHALL cover: read granted cycle N with RD_LAT=2, rst=1 in cycle N+1 -> data_ok stays 0 through N+3; a request in the cycle after rst falls is granted normally.
